blimp_writeback_commit_rob: RTL and testbench
=============================================

# blimp_writeback_commit_rob

Parametrised writeback/commit unit for the Blimp out-of-order-completion cores. It accepts results from `p_num_pipes` execute pipes through a single-grant arbiter and broadcasts each accepted result as a complete notification for rename/scoreboard wakeup. Results are buffered in a reorder buffer indexed by sequence number, and the oldest instruction is committed in program order, one per cycle, on the commit notification. It sits between the execute units and the decode-issue and fetch units, and generalises the fixed two-pipe unit to N pipes with explicit in-order retirement.

## Interface
- `p_num_pipes`, 2: number of execute pipes, 1..8
- `p_seq_num_bits`, 5: sequence-number width; ROB depth = 2^`p_seq_num_bits`
- `p_phys_addr_bits`, 6: physical register address width
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low
- `ex_val` in N: pipe i has a result
- `ex_rdy` out N: pipe i result accepted this cycle
- `ex_seq_num` in N×`p_seq_num_bits`: per-pipe sequence number
- `ex_pc` in N×32: per-pipe PC
- `ex_waddr` in N×5: per-pipe architectural destination
- `ex_preg` in N×`p_phys_addr_bits`: per-pipe new physical destination
- `ex_ppreg` in N×`p_phys_addr_bits`: per-pipe previous mapping, freed at commit
- `ex_wdata` in N×32: per-pipe result
- `ex_wen` in N: per-pipe register-write enable
- `complete_val`, `complete_seq_num`, `complete_waddr`, `complete_preg`, `complete_wdata`, `complete_wen` out: registered complete notification, same widths as the `ex_*` fields
- `commit_val`, `commit_seq_num`, `commit_pc`, `commit_waddr`, `commit_preg`, `commit_ppreg`, `commit_wdata`, `commit_wen` out: registered in-order commit notification

## Operation
- **Arbiter.**
  - At most one grant per cycle.
  - `ex_rdy[i]` = grant[i], a combinational function of `ex_val` and the arbiter pointer.
  - Producers must not make `val` depend on `rdy`.
  - A pipe holds `val` and its fields stable until it sees `rdy`.
- **Accept.** On `ex_val[i] & ex_rdy[i]`:
  - Fields are registered onto the complete outputs.
  - ROB entry [`ex_seq_num`] is written and its valid bit set.
- **Commit.**
  - Each cycle, if ROB[head] is valid, its fields load the commit outputs.
  - The entry is cleared and head increments modulo 2^`p_seq_num_bits`.
  - If ROB[head] is not valid, `commit_val` = 0 and head holds.
- **Entry ownership.** The ROB never back-pressures.
  - Upstream fetch guarantees at most 2^`p_seq_num_bits` instructions are in flight, so an accepted write never targets an occupied entry.
  - A write to an occupied entry fires a simulation-only assertion.
- **Simultaneous accept and commit.** Both happen in one cycle and touch different entries.
  - Accept can never hit head while head is valid.
  - Accept into the head entry while head is invalid is legal. The result commits the following cycle.
- **`wen` = 0 entries.** They commit with `commit_wen` = 0; data fields are don't-care.
- **Reset.**
  - `rst` low clears all ROB valid bits, head, the arbiter pointer, and every output to 0.
  - The reset takes effect immediately, including mid-operation. In-flight results are discarded.

## Timing
- `ex_rdy` is combinational in the accept cycle t.
- `complete_*` is valid in cycle t+1 for exactly one cycle.
- The ROB entry is visible from t+1. The earliest `commit_val` for that instruction is t+2.
- Throughput is one accept and one commit per cycle, sustained.
- Head wraps from 2^`p_seq_num_bits`−1 to 0 with no bubble.
- Outputs hold their last values when `*_val` = 0, except immediately after reset, when they read 0.

## Configuration
- `BLIMP_WCU_RR_ARB_EN` defined: round-robin arbitration.
  - The pointer advances to (granted index + 1) mod N after each grant.
  - The search starts at the pointer.
  - Any continuously-valid pipe is granted within N cycles.
- Undefined: fixed priority, lowest index wins. The pointer register is not instantiated.

## Test plan
- **Reset mid-stream.** Seq 0–3 are accepted, then `rst` is pulled low for one cycle → all `*_val` and `ex_rdy` read 0 immediately. After release, head = 0 and seq 0 is accepted and commits again with no stale commits.
- **Out-of-order completion.** N=2; pipe1 delivers seq 1 (wdata 0x22) at t0; pipe0 delivers seq 0 (0x11) at t3 →
  - `complete_val` appears at t1 for seq 1 and at t4 for seq 0.
  - Commits: seq 0 at t5, then seq 1 at t6.
- **Arbitration contention.** N=4, all `ex_val` held high, distinct seqs.
  - With the macro: grants 0, 1, 2, 3, 0.
  - Without the macro: grant stays on pipe 0 until it drops `val`.
- **Wrap-around.** 40 sequential single-pipe results, seq 0..31 then 0..7 → 40 commits in order with no gap. `commit_seq_num` goes from 31 to 0 on consecutive cycles.
- **`wen` = 0.** Seq 5 with `wen` = 0, `waddr` 0 → `complete_wen` = 0 and `commit_wen` = 0, and commit of seq 6 is not delayed.

Source files
------------

// File: rtl/blimp_writeback_commit_rob.sv
// blimp_writeback_commit_rob: writeback/commit unit for out-of-order-completion cores.
//
// Accepts one execute result per cycle from p_num_pipes pipes through a single-grant
// arbiter. Each accepted result is broadcast on the registered complete_* outputs and
// written into a reorder buffer indexed by its sequence number. Each cycle the entry at
// the ROB head, if valid, is retired in program order onto the registered commit_* outputs.
//
// Optional feature: define BLIMP_WCU_RR_ARB_EN for round-robin arbitration; otherwise
// fixed priority with the lowest pipe index winning.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   ex_val/ex_rdy     per-pipe result valid / grant (combinational)
//   ex_*              per-pipe result fields, flattened pipe-major (pipe i at slice i)
//   complete_*        registered one-cycle notification of the accepted result
//   commit_*          registered in-order retirement notification

module blimp_writeback_commit_rob #(
    parameter int unsigned p_num_pipes      = 2,
    parameter int unsigned p_seq_num_bits   = 5,
    parameter int unsigned p_phys_addr_bits = 6
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [p_num_pipes-1:0]                   ex_val,
    output logic [p_num_pipes-1:0]                   ex_rdy,
    input  logic [p_num_pipes*p_seq_num_bits-1:0]    ex_seq_num,
    input  logic [p_num_pipes*32-1:0]                ex_pc,
    input  logic [p_num_pipes*5-1:0]                 ex_waddr,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0]  ex_preg,
    input  logic [p_num_pipes*p_phys_addr_bits-1:0]  ex_ppreg,
    input  logic [p_num_pipes*32-1:0]                ex_wdata,
    input  logic [p_num_pipes-1:0]                   ex_wen,
    output logic                                     complete_val,
    output logic [p_seq_num_bits-1:0]                complete_seq_num,
    output logic [4:0]                               complete_waddr,
    output logic [p_phys_addr_bits-1:0]              complete_preg,
    output logic [31:0]                              complete_wdata,
    output logic                                     complete_wen,
    output logic                                     commit_val,
    output logic [p_seq_num_bits-1:0]                commit_seq_num,
    output logic [31:0]                              commit_pc,
    output logic [4:0]                               commit_waddr,
    output logic [p_phys_addr_bits-1:0]              commit_preg,
    output logic [p_phys_addr_bits-1:0]              commit_ppreg,
    output logic [31:0]                              commit_wdata,
    output logic                                     commit_wen
);

    localparam int unsigned Sw    = p_seq_num_bits;
    localparam int unsigned Pw    = p_phys_addr_bits;
    localparam int unsigned Depth = 1 << Sw;
    localparam int unsigned IdxW  = (p_num_pipes > 1) ? $clog2(p_num_pipes) : 1;

    // ---------------- Arbiter ----------------
    logic                   acc_any;
    logic [IdxW-1:0]        acc_idx;
    int unsigned            srch_idx;

`ifdef BLIMP_WCU_RR_ARB_EN
    logic [IdxW-1:0]        ptr_q, ptr_d;
`endif

    always_comb begin
        acc_any  = 1'b0;
        acc_idx  = '0;
        srch_idx = 0;
        ex_rdy   = '0;
        for (int unsigned k = 0; k < p_num_pipes; k++) begin
`ifdef BLIMP_WCU_RR_ARB_EN
            srch_idx = (k + 32'(ptr_q)) % p_num_pipes;
`else
            srch_idx = k;
`endif
            // Grant is suppressed while reset is asserted so nothing is accepted.
            if (!acc_any && ex_val[srch_idx] && rst) begin
                acc_any = 1'b1;
                acc_idx = IdxW'(srch_idx);
            end
        end
        if (acc_any) begin
            ex_rdy[acc_idx] = 1'b1;
        end
    end

`ifdef BLIMP_WCU_RR_ARB_EN
    always_comb begin
        ptr_d = ptr_q;
        if (acc_any) begin
            ptr_d = (acc_idx == IdxW'(p_num_pipes - 1)) ? '0 : acc_idx + 1'b1;
        end
    end
`endif

    // Fields of the granted pipe.
    logic [Sw-1:0]  acc_seq;
    logic [31:0]    acc_pc;
    logic [4:0]     acc_waddr;
    logic [Pw-1:0]  acc_preg;
    logic [Pw-1:0]  acc_ppreg;
    logic [31:0]    acc_wdata;
    logic           acc_wen;

    always_comb begin
        acc_seq   = ex_seq_num[acc_idx*Sw +: Sw];
        acc_pc    = ex_pc[acc_idx*32 +: 32];
        acc_waddr = ex_waddr[acc_idx*5 +: 5];
        acc_preg  = ex_preg[acc_idx*Pw +: Pw];
        acc_ppreg = ex_ppreg[acc_idx*Pw +: Pw];
        acc_wdata = ex_wdata[acc_idx*32 +: 32];
        acc_wen   = ex_wen[acc_idx];
    end

    // ---------------- Reorder buffer ----------------
    logic [Depth-1:0] rob_val_q, rob_val_d;
    logic [Sw-1:0]    head_q, head_d;
    logic [31:0]      rob_pc_q    [Depth];
    logic [4:0]       rob_waddr_q [Depth];
    logic [Pw-1:0]    rob_preg_q  [Depth];
    logic [Pw-1:0]    rob_ppreg_q [Depth];
    logic [31:0]      rob_wdata_q [Depth];
    logic             rob_wen_q   [Depth];
    logic             head_vld;

    assign head_vld = rob_val_q[head_q];

    // Clear-then-set: an accept never targets a valid head, so order only matters when
    // the accept lands on an invalid head, which must stay set.
    always_comb begin
        rob_val_d = rob_val_q;
        head_d    = head_q;
        if (head_vld) begin
            rob_val_d[head_q] = 1'b0;
            head_d            = head_q + 1'b1;
        end
        if (acc_any) begin
            rob_val_d[acc_seq] = 1'b1;
        end
    end

    // Payload storage carries no reset; validity is tracked by rob_val_q alone.
    always_ff @(posedge clk) begin
        if (acc_any) begin
            rob_pc_q[acc_seq]    <= acc_pc;
            rob_waddr_q[acc_seq] <= acc_waddr;
            rob_preg_q[acc_seq]  <= acc_preg;
            rob_ppreg_q[acc_seq] <= acc_ppreg;
            rob_wdata_q[acc_seq] <= acc_wdata;
            rob_wen_q[acc_seq]   <= acc_wen;
        end
    end

    // ---------------- Output registers ----------------
    logic           cpl_val_q, cpl_val_d;
    logic [Sw-1:0]  cpl_seq_q, cpl_seq_d;
    logic [4:0]     cpl_waddr_q, cpl_waddr_d;
    logic [Pw-1:0]  cpl_preg_q, cpl_preg_d;
    logic [31:0]    cpl_wdata_q, cpl_wdata_d;
    logic           cpl_wen_q, cpl_wen_d;

    logic           cmt_val_q, cmt_val_d;
    logic [Sw-1:0]  cmt_seq_q, cmt_seq_d;
    logic [31:0]    cmt_pc_q, cmt_pc_d;
    logic [4:0]     cmt_waddr_q, cmt_waddr_d;
    logic [Pw-1:0]  cmt_preg_q, cmt_preg_d;
    logic [Pw-1:0]  cmt_ppreg_q, cmt_ppreg_d;
    logic [31:0]    cmt_wdata_q, cmt_wdata_d;
    logic           cmt_wen_q, cmt_wen_d;

    always_comb begin
        cpl_val_d   = acc_any;
        cpl_seq_d   = cpl_seq_q;
        cpl_waddr_d = cpl_waddr_q;
        cpl_preg_d  = cpl_preg_q;
        cpl_wdata_d = cpl_wdata_q;
        cpl_wen_d   = cpl_wen_q;
        if (acc_any) begin
            cpl_seq_d   = acc_seq;
            cpl_waddr_d = acc_waddr;
            cpl_preg_d  = acc_preg;
            cpl_wdata_d = acc_wdata;
            cpl_wen_d   = acc_wen;
        end
    end

    always_comb begin
        cmt_val_d   = head_vld;
        cmt_seq_d   = cmt_seq_q;
        cmt_pc_d    = cmt_pc_q;
        cmt_waddr_d = cmt_waddr_q;
        cmt_preg_d  = cmt_preg_q;
        cmt_ppreg_d = cmt_ppreg_q;
        cmt_wdata_d = cmt_wdata_q;
        cmt_wen_d   = cmt_wen_q;
        if (head_vld) begin
            cmt_seq_d   = head_q;
            cmt_pc_d    = rob_pc_q[head_q];
            cmt_waddr_d = rob_waddr_q[head_q];
            cmt_preg_d  = rob_preg_q[head_q];
            cmt_ppreg_d = rob_ppreg_q[head_q];
            cmt_wdata_d = rob_wdata_q[head_q];
            cmt_wen_d   = rob_wen_q[head_q];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rob_val_q   <= '0;
            head_q      <= '0;
`ifdef BLIMP_WCU_RR_ARB_EN
            ptr_q       <= '0;
`endif
            cpl_val_q   <= 1'b0;
            cpl_seq_q   <= '0;
            cpl_waddr_q <= '0;
            cpl_preg_q  <= '0;
            cpl_wdata_q <= '0;
            cpl_wen_q   <= 1'b0;
            cmt_val_q   <= 1'b0;
            cmt_seq_q   <= '0;
            cmt_pc_q    <= '0;
            cmt_waddr_q <= '0;
            cmt_preg_q  <= '0;
            cmt_ppreg_q <= '0;
            cmt_wdata_q <= '0;
            cmt_wen_q   <= 1'b0;
        end else begin
            rob_val_q   <= rob_val_d;
            head_q      <= head_d;
`ifdef BLIMP_WCU_RR_ARB_EN
            ptr_q       <= ptr_d;
`endif
            cpl_val_q   <= cpl_val_d;
            cpl_seq_q   <= cpl_seq_d;
            cpl_waddr_q <= cpl_waddr_d;
            cpl_preg_q  <= cpl_preg_d;
            cpl_wdata_q <= cpl_wdata_d;
            cpl_wen_q   <= cpl_wen_d;
            cmt_val_q   <= cmt_val_d;
            cmt_seq_q   <= cmt_seq_d;
            cmt_pc_q    <= cmt_pc_d;
            cmt_waddr_q <= cmt_waddr_d;
            cmt_preg_q  <= cmt_preg_d;
            cmt_ppreg_q <= cmt_ppreg_d;
            cmt_wdata_q <= cmt_wdata_d;
            cmt_wen_q   <= cmt_wen_d;
        end
    end

    assign complete_val     = cpl_val_q;
    assign complete_seq_num = cpl_seq_q;
    assign complete_waddr   = cpl_waddr_q;
    assign complete_preg    = cpl_preg_q;
    assign complete_wdata   = cpl_wdata_q;
    assign complete_wen     = cpl_wen_q;
    assign commit_val       = cmt_val_q;
    assign commit_seq_num   = cmt_seq_q;
    assign commit_pc        = cmt_pc_q;
    assign commit_waddr     = cmt_waddr_q;
    assign commit_preg      = cmt_preg_q;
    assign commit_ppreg     = cmt_ppreg_q;
    assign commit_wdata     = cmt_wdata_q;
    assign commit_wen       = cmt_wen_q;

    // Upstream bounds in-flight instructions to the ROB depth; an overwrite means that
    // guarantee was broken.
    a_no_overwrite: assert property (@(posedge clk) disable iff (!rst)
        acc_any |-> !rob_val_q[acc_seq]);

endmodule

// File: tb/tb_blimp_writeback_commit_rob.sv
module tb_blimp_writeback_commit_rob;

    localparam int NP = 4;

    typedef struct packed {
        logic [4:0]  seq;
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [5:0]  preg;
        logic [5:0]  ppreg;
        logic [31:0] wdata;
        logic        wen;
    } item_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NP-1:0]   ex_val;
    logic [NP-1:0]   ex_rdy;
    logic [NP*5-1:0] ex_seq_num;
    logic [NP*32-1:0] ex_pc;
    logic [NP*5-1:0] ex_waddr;
    logic [NP*6-1:0] ex_preg;
    logic [NP*6-1:0] ex_ppreg;
    logic [NP*32-1:0] ex_wdata;
    logic [NP-1:0]   ex_wen;
    logic            complete_val;
    logic [4:0]      complete_seq_num;
    logic [4:0]      complete_waddr;
    logic [5:0]      complete_preg;
    logic [31:0]     complete_wdata;
    logic            complete_wen;
    logic            commit_val;
    logic [4:0]      commit_seq_num;
    logic [31:0]     commit_pc;
    logic [4:0]      commit_waddr;
    logic [5:0]      commit_preg;
    logic [5:0]      commit_ppreg;
    logic [31:0]     commit_wdata;
    logic            commit_wen;

    item_t pipe_it [NP];
    logic  pipe_v  [NP];

    for (genvar g = 0; g < NP; g++) begin : g_flat
        assign ex_val[g]            = pipe_v[g];
        assign ex_seq_num[g*5 +: 5] = pipe_it[g].seq;
        assign ex_pc[g*32 +: 32]    = pipe_it[g].pc;
        assign ex_waddr[g*5 +: 5]   = pipe_it[g].waddr;
        assign ex_preg[g*6 +: 6]    = pipe_it[g].preg;
        assign ex_ppreg[g*6 +: 6]   = pipe_it[g].ppreg;
        assign ex_wdata[g*32 +: 32] = pipe_it[g].wdata;
        assign ex_wen[g]            = pipe_it[g].wen;
    end

    blimp_writeback_commit_rob #(
        .p_num_pipes      (NP),
        .p_seq_num_bits   (5),
        .p_phys_addr_bits (6)
    ) u_dut (
        .clk              (clk),
        .rst              (rst_n),
        .ex_val           (ex_val),
        .ex_rdy           (ex_rdy),
        .ex_seq_num       (ex_seq_num),
        .ex_pc            (ex_pc),
        .ex_waddr         (ex_waddr),
        .ex_preg          (ex_preg),
        .ex_ppreg         (ex_ppreg),
        .ex_wdata         (ex_wdata),
        .ex_wen           (ex_wen),
        .complete_val     (complete_val),
        .complete_seq_num (complete_seq_num),
        .complete_waddr   (complete_waddr),
        .complete_preg    (complete_preg),
        .complete_wdata   (complete_wdata),
        .complete_wen     (complete_wen),
        .commit_val       (commit_val),
        .commit_seq_num   (commit_seq_num),
        .commit_pc        (commit_pc),
        .commit_waddr     (commit_waddr),
        .commit_preg      (commit_preg),
        .commit_ppreg     (commit_ppreg),
        .commit_wdata     (commit_wdata),
        .commit_wen       (commit_wen)
    );

    always #5 clk = ~clk;

    int    vectors = 0;
    int    miscompares = 0;
    int    model_ptr = 0;
    item_t cq[$];
    item_t mq[$];

    function automatic item_t mk(int s, int salt);
        item_t it;
        it.seq   = 5'(s % 32);
        it.pc    = 32'h8000_0000 + 32'(s * 4) + 32'(salt * 256);
        it.waddr = 5'((s * 3 + salt + 1) % 32);
        it.preg  = 6'((s + salt * 7 + 32) % 64);
        it.ppreg = 6'((s * 5 + salt + 1) % 64);
        it.wdata = 32'hC0DE_0000 ^ 32'(s << 8) ^ 32'(salt);
        it.wen   = 1'b1;
        return it;
    endfunction

    function automatic int exp_grant(logic [NP-1:0] v);
        for (int k = 0; k < NP; k++) begin
`ifdef BLIMP_WCU_RR_ARB_EN
            int j = (model_ptr + k) % NP;
`else
            int j = k;
`endif
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic drive(int p, logic v, item_t it);
        pipe_v[p]  = v;
        pipe_it[p] = it;
    endtask

    task automatic idle_all();
        for (int p = 0; p < NP; p++) pipe_v[p] = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares every complete / commit against the queued expectations.
    always @(negedge clk) begin
        item_t e;
        if (rst_n) begin
            if (complete_val) begin
                vectors++;
                if (cq.size() == 0) begin
                    miscompares++;
                    $display("FAIL complete_unexpected: got seq %0d, required no complete",
                             complete_seq_num);
                end else begin
                    e = cq.pop_front();
                    if (complete_seq_num !== e.seq || complete_waddr !== e.waddr ||
                        complete_wen !== e.wen ||
                        (e.wen && (complete_preg !== e.preg || complete_wdata !== e.wdata))) begin
                        miscompares++;
                        $display("FAIL complete_fields: got seq %0d waddr %0d preg %0d wdata %h wen %b, required seq %0d waddr %0d preg %0d wdata %h wen %b",
                                 complete_seq_num, complete_waddr, complete_preg, complete_wdata,
                                 complete_wen, e.seq, e.waddr, e.preg, e.wdata, e.wen);
                    end
                end
            end
            if (commit_val) begin
                vectors++;
                if (mq.size() == 0) begin
                    miscompares++;
                    $display("FAIL commit_unexpected: got seq %0d, required no commit",
                             commit_seq_num);
                end else begin
                    e = mq.pop_front();
                    if (commit_seq_num !== e.seq || commit_pc !== e.pc ||
                        commit_waddr !== e.waddr || commit_wen !== e.wen ||
                        (e.wen && (commit_preg !== e.preg || commit_ppreg !== e.ppreg ||
                                   commit_wdata !== e.wdata))) begin
                        miscompares++;
                        $display("FAIL commit_fields: got seq %0d pc %h waddr %0d preg %0d ppreg %0d wdata %h wen %b, required seq %0d pc %h waddr %0d preg %0d ppreg %0d wdata %h wen %b",
                                 commit_seq_num, commit_pc, commit_waddr, commit_preg,
                                 commit_ppreg, commit_wdata, commit_wen, e.seq, e.pc, e.waddr,
                                 e.preg, e.ppreg, e.wdata, e.wen);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        for (int p = 0; p < NP; p++) drive(p, 1'b1, mk(p, 9));
        step();
        @(negedge clk);
        vectors++;
        if (ex_rdy !== '0 || complete_val !== 1'b0 || commit_val !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_vals: got rdy %b cpl %b cmt %b, required 0 0 0",
                     ex_rdy, complete_val, commit_val);
        end
        vectors++;
        if (complete_seq_num !== '0 || complete_wdata !== '0 || commit_pc !== '0 ||
            commit_seq_num !== '0 || commit_ppreg !== '0 || commit_wen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fields: got cseq %0d cwdata %h mpc %h mseq %0d mppreg %0d mwen %b, required all 0",
                     complete_seq_num, complete_wdata, commit_pc, commit_seq_num,
                     commit_ppreg, commit_wen);
        end
        idle_all();
        step();
        rst_n = 1'b1;
        model_ptr = 0;
        step();
        @(negedge clk);
        vectors++;
        if (complete_val !== 1'b0 || commit_val !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_idle: got cpl %b cmt %b, required 0 0",
                     complete_val, commit_val);
        end
        step();
    endtask

    // All pipes valid at once; expected grant order comes from the bench arbiter model.
    task automatic test_contention(int h);
        int items [NP][2];
        int cnt [NP];
        int pos [NP];
        logic [NP-1:0] v;
        int g;
        int budget;
        for (int p = 0; p < NP; p++) begin
            pos[p] = 0;
            cnt[p] = 1;
            items[p][1] = 0;
        end
`ifdef BLIMP_WCU_RR_ARB_EN
        items[0][0] = h;     items[0][1] = h + 4; cnt[0] = 2;
        items[1][0] = h + 1; items[2][0] = h + 2; items[3][0] = h + 3;
`else
        items[0][0] = h;     items[0][1] = h + 1; cnt[0] = 2;
        items[1][0] = h + 2; items[2][0] = h + 3; items[3][0] = h + 4;
`endif
        for (int s = 0; s < 5; s++) mq.push_back(mk(h + s, 1));
        budget = 0;
        v = '1;
        while (v != '0 && budget < 20) begin
            v = '0;
            for (int p = 0; p < NP; p++) begin
                if (pos[p] < cnt[p]) begin
                    drive(p, 1'b1, mk(items[p][pos[p]], 1));
                    v[p] = 1'b1;
                end else begin
                    pipe_v[p] = 1'b0;
                end
            end
            if (v != '0) begin
                g = exp_grant(v);
                cq.push_back(mk(items[g][pos[g]], 1));
                @(negedge clk);
                vectors++;
                if (ex_rdy !== NP'(1 << g)) begin
                    miscompares++;
                    $display("FAIL contention_grant: got rdy %b, required %b", ex_rdy,
                             NP'(1 << g));
                end
                step();
                pos[g]++;
                model_ptr = (g + 1) % NP;
            end
            budget++;
        end
        idle_all();
        repeat (4) step();
    endtask

    task automatic test_wen0(int h);
        item_t a;
        item_t b;
        a = mk(h, 2);
        a.wen = 1'b0;
        a.waddr = 5'd0;
        b = mk(h + 1, 2);
        mq.push_back(a);
        mq.push_back(b);
        for (int c = 0; c < 5; c++) begin
            if (c == 0) begin
                drive(0, 1'b1, a); cq.push_back(a);
            end else if (c == 1) begin
                drive(0, 1'b1, b); cq.push_back(b);
            end else begin
                idle_all();
            end
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (complete_val !== 1'b1 || complete_wen !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wen0_complete: got val %b wen %b, required 1 0",
                             complete_val, complete_wen);
                end
            end
            if (c == 2) begin
                vectors++;
                if (commit_val !== 1'b1 || commit_wen !== 1'b0) begin
                    miscompares++;
                    $display("FAIL wen0_commit: got val %b wen %b, required 1 0",
                             commit_val, commit_wen);
                end
            end
            if (c == 3) begin
                vectors++;
                if (commit_val !== 1'b1 || commit_seq_num !== b.seq || commit_wen !== 1'b1) begin
                    miscompares++;
                    $display("FAIL wen0_next_commit: got val %b seq %0d wen %b, required 1 %0d 1",
                             commit_val, commit_seq_num, commit_wen, b.seq);
                end
            end
            if (c <= 1) model_ptr = 1 % NP;
            step();
        end
        idle_all();
        step();
    endtask

    task automatic test_out_of_order(int h);
        item_t a;
        item_t b;
        logic [NP-1:0] rdy_exp;
        b = mk(h + 1, 3); b.wdata = 32'h22;
        a = mk(h, 3);     a.wdata = 32'h11;
        mq.push_back(a);
        mq.push_back(b);
        for (int c = 0; c < 8; c++) begin
            idle_all();
            rdy_exp = '0;
            if (c == 0) begin
                drive(1, 1'b1, b); cq.push_back(b); rdy_exp = NP'(2);
            end
            if (c == 3) begin
                drive(0, 1'b1, a); cq.push_back(a); rdy_exp = NP'(1);
            end
            @(negedge clk);
            vectors++;
            if (ex_rdy !== rdy_exp || complete_val !== (c == 1 || c == 4) ||
                commit_val !== (c == 5 || c == 6)) begin
                miscompares++;
                $display("FAIL ooo_timing c%0d: got rdy %b cpl %b cmt %b, required %b %b %b",
                         c, ex_rdy, complete_val, commit_val, rdy_exp, (c == 1 || c == 4),
                         (c == 5 || c == 6));
            end
            if (c == 5 || c == 6) begin
                vectors++;
                if (commit_wdata !== ((c == 5) ? 32'h11 : 32'h22)) begin
                    miscompares++;
                    $display("FAIL ooo_commit_data c%0d: got %h, required %h", c, commit_wdata,
                             (c == 5) ? 32'h11 : 32'h22);
                end
            end
            if (c == 0) model_ptr = 2 % NP;
            if (c == 3) model_ptr = 1 % NP;
            step();
        end
    endtask

    task automatic test_reset_midstream(int h);
        item_t z;
        for (int s = 0; s < 3; s++) cq.push_back(mk(h + s, 4));
        for (int s = 0; s < 2; s++) mq.push_back(mk(h + s, 4));
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b1, mk(h + c, 4));
            step();
        end
        // Cycle 4: a complete and a commit are both live here; reset mid-cycle.
        z = mk(0, 5);
        drive(0, 1'b1, z);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (complete_val !== 1'b0 || commit_val !== 1'b0 || ex_rdy !== '0) begin
            miscompares++;
            $display("FAIL midreset_immediate: got cpl %b cmt %b rdy %b, required 0 0 0",
                     complete_val, commit_val, ex_rdy);
        end
        step();
        rst_n = 1'b1;
        model_ptr = 0;
        cq.push_back(z);
        mq.push_back(z);
        @(negedge clk);
        vectors++;
        if (ex_rdy !== NP'(1)) begin
            miscompares++;
            $display("FAIL midreset_regrant: got rdy %b, required %b", ex_rdy, NP'(1));
        end
        model_ptr = 1 % NP;
        step();
        idle_all();
        for (int c = 1; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (commit_val !== (c == 2)) begin
                miscompares++;
                $display("FAIL midreset_commit c%0d: got val %b seq %0d, required val %b",
                         c, commit_val, commit_seq_num, (c == 2));
            end
            step();
        end
    endtask

    task automatic test_wrap(int h);
        int prev;
        bit wrap_seen;
        prev = -1;
        wrap_seen = 1'b0;
        for (int c = 0; c < 44; c++) begin
            if (c < 40) begin
                drive(0, 1'b1, mk(h + c, 6));
                cq.push_back(mk(h + c, 6));
                mq.push_back(mk(h + c, 6));
            end else begin
                idle_all();
            end
            @(negedge clk);
            vectors++;
            if (commit_val !== (c >= 2 && c <= 41)) begin
                miscompares++;
                $display("FAIL wrap_gap c%0d: got commit_val %b, required %b", c, commit_val,
                         (c >= 2 && c <= 41));
            end
            if (commit_val) begin
                if (prev == 31) begin
                    wrap_seen = 1'b1;
                    vectors++;
                    if (commit_seq_num !== 5'd0) begin
                        miscompares++;
                        $display("FAIL wrap_seq: got %0d after 31, required 0", commit_seq_num);
                    end
                end
                prev = int'(commit_seq_num);
            end
            if (c < 40) model_ptr = 1 % NP;
            step();
        end
        vectors++;
        if (!wrap_seen) begin
            miscompares++;
            $display("FAIL wrap_seen: got no 31->0 commit transition, required one");
        end
    endtask

    initial begin
        for (int p = 0; p < NP; p++) begin
            pipe_v[p]  = 1'b0;
            pipe_it[p] = '0;
        end
        test_reset();
        test_contention(0);
        test_wen0(5);
        test_out_of_order(7);
        test_reset_midstream(9);
        test_wrap(1);
        repeat (4) step();
        vectors++;
        if (cq.size() != 0 || mq.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d completes and %0d commits outstanding, required 0 0",
                     cq.size(), mq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
